// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake/data bundle for sync_fifo.
//   master : flush, push, din, pop, clr_err out; dout, status flags, count in
//   slave  : the FIFO side (directions mirrored)
//   WIDTH  : data word width, DEPTH : entry count (sizes count to CW bits)
interface sync_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, din, pop, clr_err,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, push, din, pop, clr_err,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FWFT FIFO with inferred LUT-RAM storage, any DEPTH.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (contents discarded, memory kept)
//   bus     : sync_fifo_if.slave -- flush/push/din/pop/clr_err in;
//             dout (head word), empty, full, almost_empty, almost_full,
//             count (0..DEPTH), overflow, underflow out
// Build option: define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow;
// otherwise both read 0, clr_err is ignored and no error registers exist.
module sync_fifo #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_if.slave     bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_lap_q, wr_lap_d;
  logic          rd_lap_q, rd_lap_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_c, full_c, push_ok, pop_ok;

  // Lap bits disambiguate equal pointers: same lap = empty, differing = full.
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q) && (wr_lap_q == rd_lap_q);
    full_c  = (wr_ptr_q == rd_ptr_q) && (wr_lap_q != rd_lap_q);
    push_ok = bus.push && !full_c;
    pop_ok  = bus.pop  && !empty_c;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_lap_d = wr_lap_q;
    rd_ptr_d = rd_ptr_q;
    rd_lap_d = rd_lap_q;
    count_d  = count_q;

    if (push_ok) begin
      if (wr_ptr_q == LAST) begin
        wr_ptr_d = '0;
        wr_lap_d = ~wr_lap_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (pop_ok) begin
      if (rd_ptr_q == LAST) begin
        rd_ptr_d = '0;
        rd_lap_d = ~rd_lap_q;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end

    if (bus.flush) begin
      wr_ptr_d = '0;
      wr_lap_d = 1'b0;
      rd_ptr_d = '0;
      rd_lap_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      wr_lap_q <= 1'b0;
      rd_ptr_q <= '0;
      rd_lap_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_lap_q <= wr_lap_d;
      rd_ptr_q <= rd_ptr_d;
      rd_lap_q <= rd_lap_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.dout         = mem[rd_ptr_q];
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.count        = count_q;
  assign bus.almost_full  = 32'(count_q) >= AFULL_THRESH;
  assign bus.almost_empty = 32'(count_q) <= AEMPTY_THRESH;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A refusal in the same cycle as clr_err wins, keeping the flag set.
  always_comb begin
    overflow_d  = (overflow_q  && !bus.clr_err) || (bus.push && full_c);
    underflow_d = (underflow_q && !bus.clr_err) || (bus.pop  && empty_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo.
//   u_a : WIDTH=8, DEPTH=8 (default thresholds 6/1)
//   u_b : WIDTH=8, DEPTH=5, AFULL_THRESH=3, AEMPTY_THRESH=1
// Expected error-flag values follow SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(8), .DEPTH(8)) a_if ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(5)) b_if ();

  sync_fifo #(.WIDTH(8), .DEPTH(8)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(5), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.flush = 0; a_if.push = 0; a_if.pop = 0; a_if.clr_err = 0; a_if.din = '0;
    b_if.flush = 0; b_if.push = 0; b_if.pop = 0; b_if.clr_err = 0; b_if.din = '0;
    #12;
    chk("a_rst_empty",  a_if.empty, 1);
    chk("a_rst_aempty", a_if.almost_empty, 1);
    chk("a_rst_full",   a_if.full, 0);
    chk("a_rst_afull",  a_if.almost_full, 0);
    chk("a_rst_count",  a_if.count, 0);
    chk("b_rst_ovf",    b_if.overflow, 0);
    chk("b_rst_unf",    b_if.underflow, 0);
    rst_n = 1'b1;

    // DEPTH=8: FWFT ordering
    a_if.push = 1; a_if.din = 8'h11; step();
    chk("a_first_empty", a_if.empty, 0);
    chk("a_first_dout",  a_if.dout, 8'h11);
    chk("a_first_count", a_if.count, 1);
    chk("a_first_ae",    a_if.almost_empty, 1);
    a_if.din = 8'h22; step();
    chk("a_c2_ae", a_if.almost_empty, 0);
    a_if.din = 8'h33; step();
    a_if.push = 0;
    chk("a_c3_count", a_if.count, 3);
    chk("a_c3_dout",  a_if.dout, 8'h11);
    a_if.pop = 1; step();
    chk("a_pop1_count", a_if.count, 2);
    chk("a_pop1_dout",  a_if.dout, 8'h22);
    step();
    chk("a_pop2_count", a_if.count, 1);
    chk("a_pop2_dout",  a_if.dout, 8'h33);
    step();
    a_if.pop = 0;
    chk("a_pop3_count", a_if.count, 0);
    chk("a_pop3_empty", a_if.empty, 1);

    // DEPTH=5: fill, thresholds, overflow
    b_if.push = 1;
    b_if.din = 8'hA0; step();
    b_if.din = 8'hA1; step();
    chk("b_c2_afull", b_if.almost_full, 0);
    b_if.din = 8'hA2; step();
    chk("b_c3_afull", b_if.almost_full, 1);
    b_if.din = 8'hA3; step();
    chk("b_c4_full", b_if.full, 0);
    b_if.din = 8'hA4; step();
    chk("b_c5_full",  b_if.full, 1);
    chk("b_c5_count", b_if.count, 5);
    chk("b_c5_ovf",   b_if.overflow, 0);
    b_if.din = 8'hFF; step();
    b_if.push = 0;
    chk("b_ovf_set",   b_if.overflow, ERR_EN);
    chk("b_ovf_count", b_if.count, 5);
    chk("b_ovf_dout",  b_if.dout, 8'hA0);
    b_if.clr_err = 1; step();
    b_if.clr_err = 0;
    chk("b_clr_ovf", b_if.overflow, 0);

    // push+pop while full: only the pop goes through
    b_if.push = 1; b_if.pop = 1; b_if.din = 8'hEE; step();
    b_if.push = 0;
    chk("b_fpp_count", b_if.count, 4);
    chk("b_fpp_dout",  b_if.dout, 8'hA1);
    chk("b_fpp_full",  b_if.full, 0);
    chk("b_fpp_ovf",   b_if.overflow, ERR_EN);
    step(); chk("b_drain_a2", b_if.dout, 8'hA2);
    step(); chk("b_drain_a3", b_if.dout, 8'hA3);
    step(); chk("b_drain_a4", b_if.dout, 8'hA4);
    step();
    chk("b_drain_empty", b_if.empty, 1);
    chk("b_drain_unf",   b_if.underflow, 0);

    // push+pop while empty: only the push goes through
    b_if.push = 1; b_if.din = 8'h5A; step();
    b_if.push = 0;
    chk("b_epp_count", b_if.count, 1);
    chk("b_epp_dout",  b_if.dout, 8'h5A);
    chk("b_epp_unf",   b_if.underflow, ERR_EN);
    step();
    b_if.pop = 0;
    chk("b_epp_drain", b_if.empty, 1);

    // flush beats a concurrent push and keeps error flags
    b_if.push = 1;
    b_if.din = 8'hB1; step();
    b_if.din = 8'hB2; step();
    b_if.din = 8'hB3; step();
    chk("b_fl_pre_count", b_if.count, 3);
    b_if.flush = 1; b_if.din = 8'hCC; step();
    b_if.flush = 0; b_if.push = 0;
    chk("b_fl_count",  b_if.count, 0);
    chk("b_fl_empty",  b_if.empty, 1);
    chk("b_fl_ae",     b_if.almost_empty, 1);
    chk("b_fl_unf",    b_if.underflow, ERR_EN);
    chk("b_fl_ovf",    b_if.overflow, ERR_EN);
    b_if.clr_err = 1; b_if.pop = 1; step();
    b_if.pop = 0;
    chk("b_clr_vs_err", b_if.underflow, ERR_EN);
    step();
    b_if.clr_err = 0;
    chk("b_clr_unf", b_if.underflow, 0);
    chk("b_clr_ovf2", b_if.overflow, 0);
    b_if.push = 1; b_if.din = 8'hD1; step();
    b_if.push = 0;
    chk("b_postfl_dout",  b_if.dout, 8'hD1);
    chk("b_postfl_count", b_if.count, 1);
    b_if.pop = 1; step();
    b_if.pop = 0;
    chk("b_postfl_empty", b_if.empty, 1);

    // 13 push/pop pairs: both pointers wrap twice
    for (int i = 0; i < 13; i++) begin
      b_if.push = 1; b_if.din = 8'h30 + 8'(i); step();
      b_if.push = 0;
      chk("b_wrap_dout",  b_if.dout, 8'h30 + 8'(i));
      chk("b_wrap_empty", b_if.empty, 0);
      chk("b_wrap_full",  b_if.full, 0);
      b_if.pop = 1; step();
      b_if.pop = 0;
      chk("b_wrap_drain", b_if.empty, 1);
      chk("b_wrap_full2", b_if.full, 0);
      chk("b_wrap_count", b_if.count, 0);
    end

    // asynchronous reset mid-stream
    b_if.push = 1;
    for (int i = 0; i < 4; i++) begin
      b_if.din = 8'hF0 + 8'(i); step();
    end
    b_if.push = 0;
    chk("b_mr_pre_count", b_if.count, 4);
    chk("b_mr_pre_dout",  b_if.dout, 8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("b_mr_empty", b_if.empty, 1);
    chk("b_mr_count", b_if.count, 0);
    step();
    rst_n = 1'b1;
    b_if.push = 1; b_if.din = 8'hE1; step();
    b_if.push = 0;
    chk("b_mr_resume_dout",  b_if.dout, 8'hE1);
    chk("b_mr_resume_count", b_if.count, 1);
    b_if.pop = 1; step();
    b_if.pop = 0;
    chk("b_mr_resume_empty", b_if.empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
